// File: rtl/debounce.sv
// rtl/debounce.sv - multi-channel switch debouncer with shared sample prescaler
//
// Purpose: synchronizes WIDTH raw button inputs, samples them on a shared
// prescaled tick and accepts a new level only after STABLE_SAMPLES
// consecutive differing samples. Emits one-cycle press/release pulses.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   en           clock enable; all debounce state holds while low
//   btn_in       raw asynchronous button levels, one bit per channel
//   btn_state    debounced level per channel
//   btn_press    one-cycle pulse on debounced 0->1
//   btn_release  one-cycle pulse on debounced 1->0
//   sample_tick  one-cycle pulse marking each sample instant
module debounce #(
  parameter int WIDTH          = 2,
  parameter int SAMPLE_DIV     = 100000,
  parameter int STABLE_SAMPLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] btn_in,
  output logic [WIDTH-1:0] btn_state,
  output logic [WIDTH-1:0] btn_press,
  output logic [WIDTH-1:0] btn_release,
  output logic             sample_tick
);

  // A divider of 1 still needs a 1-bit counter that sits at 0.
  localparam int PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int CW = $clog2(STABLE_SAMPLES + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(SAMPLE_DIV - 1);
  // counter + 1 == STABLE_SAMPLES is the same as counter == STABLE_SAMPLES - 1
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_SAMPLES - 1);

  logic [WIDTH-1:0]         meta_q;
  logic [WIDTH-1:0]         sync_q;
  logic [PW-1:0]            pre_q, pre_d;
  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]         state_q, state_d;
  logic [WIDTH-1:0]         press_q, press_d;
  logic [WIDTH-1:0]         release_q, release_d;
  logic                     tick_q;
  logic                     tick;

  // Internal sample strobe; the sample_tick output is its registered copy,
  // so it lines up with the edge on which the channels act on the sample.
  assign tick = en && (pre_q == PRE_LAST);

  always_comb begin
    pre_d = pre_q;
    if (en) begin
      pre_d = tick ? '0 : pre_q + PW'(1);
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    state_d   = state_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (tick) begin
        if (sync_q[i] == state_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          cnt_d[i]     = '0;
          state_d[i]   = sync_q[i];
          press_d[i]   = sync_q[i];
          release_d[i] = ~sync_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q    <= '0;
      sync_q    <= '0;
      pre_q     <= '0;
      cnt_q     <= '0;
      state_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      tick_q    <= 1'b0;
    end else begin
      // Synchronizer runs regardless of en.
      meta_q    <= btn_in;
      sync_q    <= meta_q;
      pre_q     <= pre_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
      tick_q    <= tick;
    end
  end

  assign btn_state   = state_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign sample_tick = tick_q;

endmodule

// File: tb/tb_debounce.sv
// tb/tb_debounce.sv - directed self-checking bench for debounce
module tb_debounce;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] btn_in;
  logic [1:0] btn_state;
  logic [1:0] btn_press;
  logic [1:0] btn_release;
  logic       sample_tick;

  int checks = 0;
  int errors = 0;

  debounce #(
    .WIDTH         (2),
    .SAMPLE_DIV    (4),
    .STABLE_SAMPLES(3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .btn_in     (btn_in),
    .btn_state  (btn_state),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .sample_tick(sample_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [1:0] target, input int max, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < max && !ok) begin
      step();
      n++;
      if (btn_state == target) ok = 1'b1;
    end
  endtask

  task automatic wait_change(input logic [1:0] from, input int max, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < max && !ok) begin
      step();
      n++;
      if (btn_state != from) ok = 1'b1;
    end
  endtask

  task automatic wait_ticks(input int cnt, output bit ok);
    int seen = 0;
    for (int i = 0; i < 100 && seen < cnt; i++) begin
      step();
      if (sample_tick) seen++;
    end
    ok = (seen == cnt);
  endtask

  initial begin
    int  n;
    bit  ok;
    bit  bad;
    bit  bad0;
    int  presses;

    // Reset held with inputs high: everything stays 0.
    rst_n  = 1'b0;
    en     = 1'b1;
    btn_in = 2'b11;
    #1;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (btn_state != 0 || btn_press != 0 || btn_release != 0 || sample_tick != 0) bad = 1'b1;
      step();
    end
    if (btn_state != 0 || btn_press != 0 || btn_release != 0 || sample_tick != 0) bad = 1'b1;
    check("rst_outputs_zero", bad, 0);

    // First sample_tick 4 cycles after release.
    rst_n = 1'b1;
    step(); step(); step();
    check("tick_not_early", sample_tick, 0);
    step();
    check("tick_first", sample_tick, 1);

    // Both channels accept together 12 edges after release.
    wait_state(2'b11, 40, n, ok);
    check("both_rise_seen", ok, 1);
    check("both_rise_latency", n, 8);
    check("both_press", btn_press, 2'b11);
    check("both_press_rel", btn_release, 2'b00);
    step();
    check("both_press_clear", btn_press, 2'b00);

    // 11 -> 00 in one edge with a dual release pulse.
    btn_in = 2'b00;
    wait_change(2'b11, 40, n, ok);
    check("fall_seen", ok, 1);
    check("fall_state", btn_state, 2'b00);
    check("fall_release", btn_release, 2'b11);
    check("fall_no_press", btn_press, 2'b00);
    step();
    check("fall_release_clear", btn_release, 2'b00);

    // Single channel press latency window 11..15.
    btn_in  = 2'b01;
    n       = 0;
    presses = 0;
    while (n < 40 && btn_state == 2'b00) begin
      if (btn_press != 0) presses++;
      step();
      n++;
    end
    check("ch0_latency_ok", (n >= 11 && n <= 15), 1);
    check("ch0_state", btn_state, 2'b01);
    check("ch0_press", btn_press, 2'b01);
    check("ch0_no_release", btn_release, 2'b00);
    check("ch0_no_early_press", presses, 0);
    step();
    check("ch0_press_clear", btn_press, 2'b00);

    // Channel 1 bounces every 3 cycles: no effect on any output.
    bad  = 1'b0;
    bad0 = 1'b0;
    for (int i = 0; i < 48; i++) begin
      if (i % 3 == 0) btn_in[1] = ~btn_in[1];
      step();
      if (btn_state[1] || btn_press[1] || btn_release[1]) bad = 1'b1;
      if (!btn_state[0] || btn_press[0] || btn_release[0]) bad0 = 1'b1;
    end
    btn_in[1] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (btn_state[1] || btn_press[1] || btn_release[1]) bad = 1'b1;
      if (!btn_state[0] || btn_press[0] || btn_release[0]) bad0 = 1'b1;
    end
    check("bounce_ch1_quiet", bad, 0);
    check("bounce_ch0_steady", bad0, 0);

    // Clock enable freeze after two counted samples.
    btn_in = 2'b00;
    wait_state(2'b00, 40, n, ok);
    check("en_prep_clear", ok, 1);
    btn_in = 2'b01;
    step(); step();
    wait_ticks(2, ok);
    check("en_two_ticks", ok, 1);
    en  = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (btn_state != 0 || btn_press != 0 || btn_release != 0 || sample_tick != 0) bad = 1'b1;
    end
    check("en_low_frozen", bad, 0);
    en = 1'b1;
    step(); step(); step();
    check("en_resume_hold", btn_state, 2'b00);
    step();
    check("en_resume_state", btn_state, 2'b01);
    check("en_resume_press", btn_press, 2'b01);
    check("en_resume_tick", sample_tick, 1);

    // Reset pulse mid-count discards progress.
    btn_in = 2'b00;
    wait_state(2'b00, 40, n, ok);
    check("rst_prep_clear", ok, 1);
    btn_in = 2'b01;
    step(); step();
    wait_ticks(2, ok);
    check("rst_two_ticks", ok, 1);
    rst_n = 1'b0;
    #1;
    check("rst_pulse_state", btn_state, 2'b00);
    step();
    rst_n   = 1'b1;
    presses = 0;
    for (int i = 0; i < 11; i++) begin
      step();
      if (btn_press != 0) presses++;
    end
    check("rst_full_latency_hold", btn_state, 2'b00);
    check("rst_no_early_press", presses, 0);
    step();
    check("rst_after_state", btn_state, 2'b01);
    check("rst_after_press", btn_press, 2'b01);
    step();
    check("rst_after_press_clear", btn_press, 2'b00);

    // Asynchronous reset between clock edges.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_state", btn_state, 2'b00);
    rst_n = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
